// File: rtl/ysyx_23060332_ctrl.sv
// ysyx_23060332_ctrl -- multi-cycle instruction sequencer for the NPC core.
// Owns the PC, fetches one instruction at a time over a valid/ready port,
// holds it for decode/execute, optionally waits on a data-memory access and
// then issues a one-cycle commit pulse. Halts permanently on trap.
// Optional feature: define CTRL_TIMEOUT_EN to add a per-handshake watchdog
// (8-bit saturating counter, sticky timeout flag, forced halt). When it is
// not defined the TIMEOUT_CYCLES parameter does not exist and timeout is 0.
module ysyx_23060332_ctrl #(
  parameter logic [31:0] RESET_PC       = 32'h8000_0000
`ifdef CTRL_TIMEOUT_EN
  , parameter logic [7:0]  TIMEOUT_CYCLES = 8'd255
`endif
) (
  input  logic        clk,
  input  logic        rst_n,
  // instruction memory
  output logic        if_req_valid,
  input  logic        if_req_ready,
  output logic [31:0] if_addr,
  input  logic        if_rsp_valid,
  input  logic [31:0] if_rsp_data,
  // decode / execute
  output logic [31:0] inst_o,
  output logic [31:0] pc,
  input  logic        jump_en,
  input  logic [31:0] jump_addr,
  input  logic        mem_need,
  // data memory
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  input  logic        mem_done,
  // status
  input  logic        trap,
  output logic        commit,
  output logic        halted,
  output logic        timeout
);

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef enum logic [2:0] {
    S_IF_REQ,
    S_IF_WAIT,
    S_EXEC,
    S_MEM_REQ,
    S_MEM_WAIT,
    S_WB,
    S_HALT
  } state_t;

  state_t state, state_next;
  logic   tmo_hit;  // watchdog expired this cycle without the awaited handshake

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    if (!rst_n) state <= S_IF_REQ;
    else        state <= state_next;
  end

  // Next-state logic; a watchdog expiry overrides the normal transition.
  always_comb begin
    // NOTE: default assigned first so no path leaves state_next unassigned,
    // which would otherwise infer a latch.
    state_next = state;
    unique case (state)
      S_IF_REQ:   if (if_req_ready) state_next = S_IF_WAIT;
      S_IF_WAIT:  if (if_rsp_valid) state_next = S_EXEC;
      S_EXEC: begin
        if (trap)          state_next = S_HALT;
        else if (mem_need) state_next = S_MEM_REQ;
        else               state_next = S_WB;
      end
      S_MEM_REQ:  if (mem_req_ready) state_next = S_MEM_WAIT;
      S_MEM_WAIT: if (mem_done)      state_next = S_WB;
      S_WB:       state_next = S_IF_REQ;
      S_HALT:     state_next = S_HALT;
      default:    state_next = S_HALT;
    endcase
    if (tmo_hit) state_next = S_HALT;
  end

  // Moore outputs decoded from state only.
  assign if_req_valid  = (state == S_IF_REQ);
  assign mem_req_valid = (state == S_MEM_REQ);
  assign commit        = (state == S_WB);
  assign halted        = (state == S_HALT);
  assign if_addr       = pc;

  // PC and held instruction: captured only at fetch response and writeback.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc     <= RESET_PC;
      inst_o <= NOP_INST;
    end else begin
      if (state == S_IF_WAIT && if_rsp_valid) inst_o <= if_rsp_data;
      if (state == S_WB) begin
        // Jump targets are forced halfword-aligned; sequential PC wraps mod 2^32.
        pc <= jump_en ? {jump_addr[31:1], 1'b0} : pc + 32'd4;
      end
    end
  end

`ifdef CTRL_TIMEOUT_EN
  logic [7:0] wait_cnt;
  logic       timeout_q;
  logic       in_wait;
  logic       handshake;

  assign in_wait = (state == S_IF_REQ)  || (state == S_IF_WAIT) ||
                   (state == S_MEM_REQ) || (state == S_MEM_WAIT);

  // The handshake each waiting state is blocked on.
  always_comb begin
    handshake = 1'b0;
    unique case (state)
      S_IF_REQ:   handshake = if_req_ready;
      S_IF_WAIT:  handshake = if_rsp_valid;
      S_MEM_REQ:  handshake = mem_req_ready;
      S_MEM_WAIT: handshake = mem_done;
      default:    handshake = 1'b0;
    endcase
  end

  // The cycle in which the count would reach the limit is the expiry cycle.
  assign tmo_hit = in_wait && !handshake &&
                   (({1'b0, wait_cnt} + 9'd1) >= {1'b0, TIMEOUT_CYCLES});

  // Cycle counter: restarts on every state change, saturates at all-ones.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wait_cnt  <= 8'd0;
      timeout_q <= 1'b0;
    end else begin
      if (tmo_hit) timeout_q <= 1'b1;
      if (state_next != state)              wait_cnt <= 8'd0;
      else if (in_wait && wait_cnt != 8'hFF) wait_cnt <= wait_cnt + 8'd1;
    end
  end

  assign timeout = timeout_q;
`else
  assign tmo_hit = 1'b0;
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_ysyx_23060332_ctrl.sv
// Directed self-checking bench for ysyx_23060332_ctrl. Inputs are driven 1ns
// after the rising edge and outputs are checked in that same window.
module tb_ysyx_23060332_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req_valid, if_req_ready;
  logic [31:0] if_addr;
  logic        if_rsp_valid;
  logic [31:0] if_rsp_data;
  logic [31:0] inst_o, pc;
  logic        jump_en;
  logic [31:0] jump_addr;
  logic        mem_need, mem_req_valid, mem_req_ready, mem_done;
  logic        trap, commit, halted, timeout;

  int vec_cnt = 0;
  int err_cnt = 0;

  always #5 clk = ~clk;

  ysyx_23060332_ctrl #(
    .RESET_PC       (32'h8000_0000)
`ifdef CTRL_TIMEOUT_EN
    , .TIMEOUT_CYCLES (8'd8)
`endif
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .if_req_valid  (if_req_valid),
    .if_req_ready  (if_req_ready),
    .if_addr       (if_addr),
    .if_rsp_valid  (if_rsp_valid),
    .if_rsp_data   (if_rsp_data),
    .inst_o        (inst_o),
    .pc            (pc),
    .jump_en       (jump_en),
    .jump_addr     (jump_addr),
    .mem_need      (mem_need),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_done      (mem_done),
    .trap          (trap),
    .commit        (commit),
    .halted        (halted),
    .timeout       (timeout)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;  if_req_ready = 1'b1; if_rsp_valid = 1'b1;
    if_rsp_data = 32'h0010_0093; jump_en = 1'b0; jump_addr = 32'h0;
    mem_need = 1'b0; mem_req_ready = 1'b0; mem_done = 1'b0; trap = 1'b0;
    tick(); tick();

    // Reset state
    check("rst_pc", pc, 32'h8000_0000);
    check("rst_inst", inst_o, 32'h0000_0013);
    check("rst_commit", {31'b0, commit}, 32'd0);
    check("rst_halted", {31'b0, halted}, 32'd0);
    check("rst_timeout", {31'b0, timeout}, 32'd0);

    // Best-case fetch of addi x1,x0,1: IF_REQ, IF_WAIT, EXEC, WB
    rst_n = 1'b1;
    check("c1_valid", {31'b0, if_req_valid}, 32'd1);
    check("c1_addr", if_addr, 32'h8000_0000);
    tick();
    check("c2_valid", {31'b0, if_req_valid}, 32'd0);
    check("c2_commit", {31'b0, commit}, 32'd0);
    tick();
    check("c3_inst", inst_o, 32'h0010_0093);
    check("c3_commit", {31'b0, commit}, 32'd0);
    tick();
    check("c4_commit", {31'b0, commit}, 32'd1);
    check("c4_pc", pc, 32'h8000_0000);
    tick();
    check("c5_commit", {31'b0, commit}, 32'd0);
    check("c5_addr", if_addr, 32'h8000_0004);

    // Fetch stall: ready low for 3 cycles, valid and address held
    if_req_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("stall_valid", {31'b0, if_req_valid}, 32'd1);
      check("stall_addr", if_addr, 32'h8000_0004);
      check("stall_commit", {31'b0, commit}, 32'd0);
      tick();
    end
    if_req_ready = 1'b1;
    if_rsp_data  = 32'h0000_006f;
    check("stall_valid4", {31'b0, if_req_valid}, 32'd1);
    tick();
    check("stall_acc", {31'b0, if_req_valid}, 32'd0);
    tick();
    // EXEC of jal: jump to odd target, low bit cleared
    jump_en = 1'b1; jump_addr = 32'h8000_0011;
    tick();
    check("jal_commit", {31'b0, commit}, 32'd1);
    tick();
    jump_en = 1'b0;
    check("jal_pc", pc, 32'h8000_0010);
    check("jal_addr", if_addr, 32'h8000_0010);

    // Load with memory access; mem_done four cycles into MEM_WAIT
    if_rsp_data = 32'h0000_a083;
    tick();
    tick();
    check("ld_inst", inst_o, 32'h0000_a083);
    mem_need = 1'b1;
    tick();
    check("ld_mreq", {31'b0, mem_req_valid}, 32'd1);
    check("ld_mreq_commit", {31'b0, commit}, 32'd0);
    mem_req_ready = 1'b1;
    tick();
    // i = 0 is the MEM_WAIT entry cycle
    for (int i = 0; i < 8; i++) begin
      mem_done = (i == 4);
      check($sformatf("ld_commit_%0d", i), {31'b0, commit}, {31'b0, (i == 5)});
      check($sformatf("ld_pc_%0d", i), pc, (i <= 5) ? 32'h8000_0010 : 32'h8000_0014);
      if (i == 0) check("ld_mreq_drop", {31'b0, mem_req_valid}, 32'd0);
      tick();
    end
    mem_done = 1'b0;
    mem_need = 1'b0;
    // Now in EXEC of the refetched load -> WB -> IF_REQ at 0x8000_0018
    tick();
    tick();
    check("seq_pc", pc, 32'h8000_0018);

    // ebreak with trap (and mem_need, which trap overrides)
    if_rsp_data = 32'h0010_0073;
    tick();
    tick();
    check("ebk_inst", inst_o, 32'h0010_0073);
    trap = 1'b1; mem_need = 1'b1; mem_req_ready = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      check("halt_halted", {31'b0, halted}, 32'd1);
      check("halt_commit", {31'b0, commit}, 32'd0);
      check("halt_ifreq", {31'b0, if_req_valid}, 32'd0);
      check("halt_mreq", {31'b0, mem_req_valid}, 32'd0);
      check("halt_pc", pc, 32'h8000_0018);
      tick();
    end
    rst_n = 1'b0; trap = 1'b0; mem_need = 1'b0; mem_req_ready = 1'b0;
    tick();
    check("rst2_pc", pc, 32'h8000_0000);
    check("rst2_halted", {31'b0, halted}, 32'd0);
    check("rst2_inst", inst_o, 32'h0000_0013);
    check("rst2_valid", {31'b0, if_req_valid}, 32'd1);

    // Reset in the middle of a fetch wait abandons it without commit
    rst_n = 1'b1; if_rsp_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("abort_pc", pc, 32'h8000_0000);
    check("abort_valid", {31'b0, if_req_valid}, 32'd1);
    check("abort_commit", {31'b0, commit}, 32'd0);

`ifdef CTRL_TIMEOUT_EN
    // Response never arrives: timeout after 8 IF_WAIT cycles
    tick();  // enter IF_WAIT
    for (int i = 0; i < 8; i++) begin
      check("tmo_pending", {31'b0, timeout}, 32'd0);
      check("tmo_nohalt", {31'b0, halted}, 32'd0);
      tick();
    end
    check("tmo_flag", {31'b0, timeout}, 32'd1);
    check("tmo_halted", {31'b0, halted}, 32'd1);
    if_rsp_valid = 1'b1;
    tick();
    check("tmo_sticky", {31'b0, timeout}, 32'd1);
`else
    // Without the watchdog the fetch simply keeps waiting
    for (int i = 0; i < 20; i++) tick();
    check("wait_timeout", {31'b0, timeout}, 32'd0);
    check("wait_halted", {31'b0, halted}, 32'd0);
    check("wait_inst", inst_o, 32'h0000_0013);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
